// File: rtl/pingpong_dpram_pkg.sv
// Shared bank-state encoding and default geometry for the ping-pong buffer.
// Purely declarative: no logic, so no latency or backpressure of its own.
package pingpong_dpram_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    localparam int DEF_DWIDTH = 60;
    localparam int DEF_AWIDTH = 11;

endpackage

// File: rtl/pingpong_dpram_dpram_generic.sv
// True dual-port RAM, synchronous 1-cycle read, no reset, no backpressure.
// Two writes to the same address in one cycle: port A lands last and wins.
module dpram_generic #(
    parameter int DWIDTH = 60,
    parameter int AWIDTH = 11
) (
    input  logic              i_clk,
    input  logic              i_we_a,
    input  logic [AWIDTH-1:0] i_addr_a,
    input  logic [DWIDTH-1:0] i_dat_a,
    output logic [DWIDTH-1:0] o_q_a,
    input  logic              i_we_b,
    input  logic [AWIDTH-1:0] i_addr_b,
    input  logic [DWIDTH-1:0] i_dat_b,
    output logic [DWIDTH-1:0] o_q_b
);

    logic [DWIDTH-1:0] r_mem [0:(2**AWIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_we_b) r_mem[i_addr_b] <= i_dat_b;
        if (i_we_a) r_mem[i_addr_a] <= i_dat_a;
        o_q_a <= r_mem[i_addr_a];
        o_q_b <= r_mem[i_addr_b];
    end

endmodule

// File: rtl/pingpong_dpram.sv
// Double-buffered dual-port RAM; banks swap owner only on wr_done/rd_done pulses.
// Read latency 1 cycle; producer is throttled by wr_ready, consumer by rd_valid.
module pingpong_dpram
    import pingpong_dpram_pkg::*;
#(
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int NUM_WORDS = 2**DEF_AWIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [AWIDTH-1:0] i_wr_address_a,
    input  logic [AWIDTH-1:0] i_wr_address_b,
    input  logic              i_wr_en_a,
    input  logic              i_wr_en_b,
    input  logic [DWIDTH-1:0] i_wr_data_a,
    input  logic [DWIDTH-1:0] i_wr_data_b,
    input  logic              i_wr_done,
    output logic              o_wr_ready,
    input  logic [AWIDTH-1:0] i_rd_address_a,
    input  logic [AWIDTH-1:0] i_rd_address_b,
    input  logic              i_rd_done,
    output logic              o_rd_valid,
    output logic [DWIDTH-1:0] o_out_a,
    output logic [DWIDTH-1:0] o_out_b,
    output logic              o_fill_bank,
    output logic              o_drain_bank,
    output logic              o_wr_overflow,
    output logic              o_rd_underflow
);

    if (NUM_WORDS != (2**AWIDTH)) begin : g_bad_depth
        $error("pingpong_dpram: NUM_WORDS must equal 2**AWIDTH");
    end

    bank_state_t r_state [2];
    logic        r_fill_ptr;
    logic        r_drain_ptr;
    logic        r_wr_overflow;
    logic        r_rd_underflow;
    logic        r_rd_sel;
    logic        r_rd_live;

    bank_state_t w_state_nxt [2];
    logic        w_fill_nxt;
    logic        w_drain_nxt;
    logic        w_wr_overflow_nxt;
    logic        w_rd_underflow_nxt;
    logic        w_wr_ready;
    logic        w_rd_valid;

    logic [DWIDTH-1:0] w_q_a [2];
    logic [DWIDTH-1:0] w_q_b [2];

    assign w_wr_ready = (r_state[r_fill_ptr]  == BANK_EMPTY);
    assign w_rd_valid = (r_state[r_drain_ptr] == BANK_FULL);

    // wr_done needs EMPTY and rd_done needs FULL, so both pulses in one cycle
    // always hit different banks and can be applied independently.
    always_comb begin
        w_state_nxt        = r_state;
        w_fill_nxt         = r_fill_ptr;
        w_drain_nxt        = r_drain_ptr;
        w_wr_overflow_nxt  = r_wr_overflow;
        w_rd_underflow_nxt = r_rd_underflow;
        if (i_wr_done && w_wr_ready) begin
            w_state_nxt[r_fill_ptr] = BANK_FULL;
            w_fill_nxt              = ~r_fill_ptr;
        end
        if (i_rd_done && w_rd_valid) begin
            w_state_nxt[r_drain_ptr] = BANK_EMPTY;
            w_drain_nxt              = ~r_drain_ptr;
        end
        if (!w_wr_ready && (i_wr_en_a || i_wr_en_b || i_wr_done)) begin
            w_wr_overflow_nxt = 1'b1;
        end
        if (!w_rd_valid && i_rd_done) begin
            w_rd_underflow_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state[0]     <= BANK_EMPTY;
            r_state[1]     <= BANK_EMPTY;
            r_fill_ptr     <= 1'b0;
            r_drain_ptr    <= 1'b0;
            r_wr_overflow  <= 1'b0;
            r_rd_underflow <= 1'b0;
            r_rd_sel       <= 1'b0;
            r_rd_live      <= 1'b0;
        end else begin
            r_state[0]     <= w_state_nxt[0];
            r_state[1]     <= w_state_nxt[1];
            r_fill_ptr     <= w_fill_nxt;
            r_drain_ptr    <= w_drain_nxt;
            r_wr_overflow  <= w_wr_overflow_nxt;
            r_rd_underflow <= w_rd_underflow_nxt;
            r_rd_sel       <= r_drain_ptr;
            r_rd_live      <= w_rd_valid;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        logic              w_wr_own;
        logic              w_we_a;
        logic              w_we_b;
        logic [AWIDTH-1:0] w_addr_a;
        logic [AWIDTH-1:0] w_addr_b;

        // A bank not owned by the producer only ever sees read addresses, so
        // the draining bank and the idle bank share the same routing.
        assign w_wr_own = (r_state[i] == BANK_EMPTY) && (r_fill_ptr == 1'(i));
        assign w_addr_a = w_wr_own ? i_wr_address_a : i_rd_address_a;
        assign w_addr_b = w_wr_own ? i_wr_address_b : i_rd_address_b;
        assign w_we_a   = w_wr_own && i_wr_en_a;
        assign w_we_b   = w_wr_own && i_wr_en_b &&
                          !(i_wr_en_a && (i_wr_address_a == i_wr_address_b));

        dpram_generic #(
            .DWIDTH (DWIDTH),
            .AWIDTH (AWIDTH)
        ) u_ram (
            .i_clk    (i_clk),
            .i_we_a   (w_we_a),
            .i_addr_a (w_addr_a),
            .i_dat_a  (i_wr_data_a),
            .o_q_a    (w_q_a[i]),
            .i_we_b   (w_we_b),
            .i_addr_b (w_addr_b),
            .i_dat_b  (i_wr_data_b),
            .o_q_b    (w_q_b[i])
        );
    end

    // Output is forced to zero unless the previous cycle read a FULL bank, which
    // also gives a defined value out of reset despite the RAM not being reset.
    assign o_out_a        = r_rd_live ? w_q_a[r_rd_sel] : '0;
    assign o_out_b        = r_rd_live ? w_q_b[r_rd_sel] : '0;
    assign o_wr_ready     = w_wr_ready;
    assign o_rd_valid     = w_rd_valid;
    assign o_fill_bank    = r_fill_ptr;
    assign o_drain_bank   = r_drain_ptr;
    assign o_wr_overflow  = r_wr_overflow;
    assign o_rd_underflow = r_rd_underflow;

endmodule

// File: tb/tb_pingpong_dpram.sv
// Bench for pingpong_dpram: random data against a bank-array reference model.
module tb_pingpong_dpram;

    localparam int DW = 60;
    localparam int AW = 11;
    localparam int NW = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wa_a = '0, wa_b = '0, ra_a = '0, ra_b = '0;
    logic          we_a = 1'b0, we_b = 1'b0, wr_done = 1'b0, rd_done = 1'b0;
    logic [DW-1:0] wd_a = '0, wd_b = '0;
    logic          wr_ready, rd_valid, fill_bank, drain_bank, wr_ovf, rd_unf;
    logic [DW-1:0] out_a, out_b;

    logic [DW-1:0] m_mem [2][NW];
    bit            m_full [2];
    bit            m_fill, m_drain, m_ovf, m_unf;
    bit            exp_live;
    logic [DW-1:0] exp_a, exp_b;
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    pingpong_dpram #(.DWIDTH(DW), .AWIDTH(AW), .NUM_WORDS(NW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wr_address_a (wa_a),
        .i_wr_address_b (wa_b),
        .i_wr_en_a      (we_a),
        .i_wr_en_b      (we_b),
        .i_wr_data_a    (wd_a),
        .i_wr_data_b    (wd_b),
        .i_wr_done      (wr_done),
        .o_wr_ready     (wr_ready),
        .i_rd_address_a (ra_a),
        .i_rd_address_b (ra_b),
        .i_rd_done      (rd_done),
        .o_rd_valid     (rd_valid),
        .o_out_a        (out_a),
        .o_out_b        (out_b),
        .o_fill_bank    (fill_bank),
        .o_drain_bank   (drain_bank),
        .o_wr_overflow  (wr_ovf),
        .o_rd_underflow (rd_unf)
    );

    function automatic logic [DW-1:0] rnd_word();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_fill = 0; m_drain = 0; m_ovf = 0; m_unf = 0;
        exp_live = 0;
    endtask

    // One clock: the model applies the same rules to the inputs held across the edge.
    task automatic cycle();
        bit ready, valid;
        ready = !m_full[m_fill];
        valid = m_full[m_drain];
        exp_live = valid;
        if (valid) begin
            exp_a = m_mem[m_drain][ra_a];
            exp_b = m_mem[m_drain][ra_b];
        end
        @(posedge clk);
        if (!ready && (we_a || we_b || wr_done)) m_ovf = 1;
        if (ready) begin
            if (we_b) m_mem[m_fill][wa_b] = wd_b;
            if (we_a) m_mem[m_fill][wa_a] = wd_a;
        end
        if (wr_done && ready) begin m_full[m_fill] = 1; m_fill = !m_fill; end
        if (rd_done && valid) begin m_full[m_drain] = 0; m_drain = !m_drain; end
        else if (rd_done) m_unf = 1;
        @(negedge clk);
        we_a = 0; we_b = 0; wr_done = 0; rd_done = 0;
    endtask

    task automatic fill_words(input bit addr_data);
        for (int k = 0; k < NW / 2; k++) begin
            wa_a = AW'(2 * k);
            wa_b = AW'(2 * k + 1);
            we_a = 1; we_b = 1;
            wd_a = addr_data ? DW'(2 * k) : rnd_word();
            wd_b = addr_data ? DW'(2 * k + 1) : rnd_word();
            cycle();
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (out_a !== '0) $display("FAIL reset_out_a: got %0h want 0", out_a); else n_pass++;
        n_checks++; if (out_b !== '0) $display("FAIL reset_out_b: got %0h want 0", out_b); else n_pass++;
        n_checks++; if (wr_ovf !== 1'b0 || rd_unf !== 1'b0)
            $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", wr_ovf, rd_unf); else n_pass++;
        n_checks++; if (fill_bank !== 1'b0 || drain_bank !== 1'b0)
            $display("FAIL reset_ptrs: got fill=%b drain=%b want 0 0", fill_bank, drain_bank); else n_pass++;
    endtask

    task automatic test_fill_bank0();
        fill_words(1);
        wr_done = 1;
        cycle();
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL fill0_rd_valid: got %b want 1", rd_valid); else n_pass++;
        n_checks++; if (fill_bank !== 1'b1) $display("FAIL fill0_fill_bank: got %b want 1", fill_bank); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL fill0_wr_ready: got %b want 1", wr_ready); else n_pass++;
        ra_a = AW'(5); ra_b = AW'(2047);
        cycle();
        n_checks++; if (out_a !== DW'(5)) $display("FAIL fill0_read5: got %0h want 5", out_a); else n_pass++;
        n_checks++; if (out_b !== DW'(2047)) $display("FAIL fill0_read2047: got %0h want 7ff", out_b); else n_pass++;
        for (int k = 0; k < 32; k++) begin
            ra_a = AW'($urandom_range(0, NW - 1));
            ra_b = AW'($urandom_range(0, NW - 1));
            cycle();
            n_checks++; if (!exp_live || out_a !== exp_a)
                $display("FAIL fill0_rand_a: got %0h want %0h live=%b", out_a, exp_a, exp_live); else n_pass++;
            n_checks++; if (!exp_live || out_b !== exp_b)
                $display("FAIL fill0_rand_b: got %0h want %0h live=%b", out_b, exp_b, exp_live); else n_pass++;
        end
    endtask

    task automatic test_concurrent_swap();
        for (int k = 0; k < NW / 2; k++) begin
            wa_a = AW'(2 * k); wa_b = AW'(2 * k + 1);
            we_a = 1; we_b = 1;
            wd_a = rnd_word(); wd_b = rnd_word();
            ra_a = AW'($urandom_range(0, NW - 1));
            ra_b = AW'($urandom_range(0, NW - 1));
            cycle();
            if (exp_live) begin
                n_checks++; if (out_a !== exp_a) $display("FAIL concur_read_a: got %0h want %0h", out_a, exp_a); else n_pass++;
                n_checks++; if (out_b !== exp_b) $display("FAIL concur_read_b: got %0h want %0h", out_b, exp_b); else n_pass++;
            end
        end
        ra_a = AW'(9); ra_b = AW'(1000);
        wr_done = 1; rd_done = 1;
        cycle();
        n_checks++; if (out_a !== exp_a || out_b !== exp_b)
            $display("FAIL swap_read_on_done: got %0h %0h want %0h %0h", out_a, out_b, exp_a, exp_b); else n_pass++;
        n_checks++; if (fill_bank !== 1'b0 || drain_bank !== 1'b1)
            $display("FAIL swap_ptrs: got fill=%b drain=%b want 0 1", fill_bank, drain_bank); else n_pass++;
        n_checks++; if (rd_valid !== 1'b1 || wr_ready !== 1'b1)
            $display("FAIL swap_status: got valid=%b ready=%b want 1 1", rd_valid, wr_ready); else n_pass++;
        n_checks++; if (wr_ovf !== 1'b0 || rd_unf !== 1'b0)
            $display("FAIL swap_flags: got ovf=%b unf=%b want 0 0", wr_ovf, rd_unf); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] orig;
        fill_words(0);
        wr_done = 1;
        cycle();
        n_checks++; if (wr_ready !== 1'b0) $display("FAIL ovf_wr_ready: got %b want 0", wr_ready); else n_pass++;
        orig = m_mem[1][3];
        wa_a = AW'(3); wd_a = ~orig; we_a = 1;
        cycle();
        n_checks++; if (wr_ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", wr_ovf); else n_pass++;
        n_checks++; if (rd_unf !== m_unf) $display("FAIL ovf_unf: got %b want %b", rd_unf, m_unf); else n_pass++;
        ra_a = AW'(3); ra_b = AW'($urandom_range(0, NW - 1));
        cycle();
        n_checks++; if (out_a !== orig) $display("FAIL ovf_addr3_kept: got %0h want %0h", out_a, orig); else n_pass++;
        n_checks++; if (out_b !== exp_b) $display("FAIL ovf_read_b: got %0h want %0h", out_b, exp_b); else n_pass++;
    endtask

    task automatic test_underflow_collision();
        rd_done = 1; cycle();
        rd_done = 1; cycle();
        n_checks++; if (rd_valid !== 1'b0 || rd_unf !== 1'b0)
            $display("FAIL unf_drained: got valid=%b unf=%b want 0 0", rd_valid, rd_unf); else n_pass++;
        rd_done = 1; cycle();
        n_checks++; if (rd_unf !== 1'b1) $display("FAIL unf_flag: got %b want 1", rd_unf); else n_pass++;
        n_checks++; if (drain_bank !== m_drain) $display("FAIL unf_ptr_held: got %b want %b", drain_bank, m_drain); else n_pass++;
        wa_a = AW'(7); wa_b = AW'(7); wd_a = DW'(4'hA); wd_b = DW'(4'hB);
        we_a = 1; we_b = 1;
        cycle();
        wr_done = 1; cycle();
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL coll_rd_valid: got %b want 1", rd_valid); else n_pass++;
        ra_a = AW'(7); ra_b = AW'(7);
        cycle();
        n_checks++; if (out_a !== DW'(4'hA)) $display("FAIL coll_port_a_wins_a: got %0h want a", out_a); else n_pass++;
        n_checks++; if (out_b !== DW'(4'hA)) $display("FAIL coll_port_a_wins_b: got %0h want a", out_b); else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 100; k++) begin
            wa_a = AW'(2 * k); wa_b = AW'(2 * k + 1);
            we_a = 1; we_b = 1;
            wd_a = rnd_word(); wd_b = rnd_word();
            cycle();
        end
        #3 rst_n = 0;
        #1;
        n_checks++; if (wr_ready !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL mrst_status: got ready=%b valid=%b want 1 0", wr_ready, rd_valid); else n_pass++;
        n_checks++; if (fill_bank !== 1'b0 || drain_bank !== 1'b0)
            $display("FAIL mrst_ptrs: got fill=%b drain=%b want 0 0", fill_bank, drain_bank); else n_pass++;
        n_checks++; if (wr_ovf !== 1'b0 || rd_unf !== 1'b0)
            $display("FAIL mrst_flags: got ovf=%b unf=%b want 0 0", wr_ovf, rd_unf); else n_pass++;
        n_checks++; if (out_a !== '0 || out_b !== '0)
            $display("FAIL mrst_out: got %0h %0h want 0 0", out_a, out_b); else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        fill_words(0);
        wr_done = 1;
        cycle();
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL mrst_refill_valid: got %b want 1", rd_valid); else n_pass++;
        for (int k = 0; k < 32; k++) begin
            ra_a = AW'($urandom_range(0, NW - 1));
            ra_b = AW'($urandom_range(0, NW - 1));
            cycle();
            n_checks++; if (!exp_live || out_a !== exp_a || out_b !== exp_b)
                $display("FAIL mrst_drain: got %0h %0h want %0h %0h", out_a, out_b, exp_a, exp_b); else n_pass++;
        end
        rd_done = 1;
        cycle();
        n_checks++; if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || wr_ovf !== 1'b0 || rd_unf !== 1'b0)
            $display("FAIL mrst_final: got valid=%b ready=%b ovf=%b unf=%b want 0 1 0 0",
                     rd_valid, wr_ready, wr_ovf, rd_unf); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_bank0();
        test_concurrent_swap();
        test_overflow();
        test_underflow_collision();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pingpong_dpram.md
# pingpong_dpram

Parametrised double-buffered (ping-pong) dual-port RAM with explicit bank-ownership handshaking. A producer fills one bank through two write ports while a consumer drains the other through two read ports. Banks change hands only on explicit done pulses, with per-bank FULL/EMPTY tracking. It sits between tile-producing compute stages and consuming stages in the accelerator datapath. It replaces free-running bank toggling with flow-controlled swaps.

## Interface
- DWIDTH, 60, data width per word
- AWIDTH, 11, address width
- NUM_WORDS, 2048, words per bank (must equal 2**AWIDTH)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_address_a, wr_address_b  in  AWIDTH  producer write addresses
- wr_en_a, wr_en_b  in  1  producer write enables
- wr_data_a, wr_data_b  in  DWIDTH  producer write data
- wr_done  in  1  one-cycle pulse: current fill bank complete
- wr_ready  out  1  a bank is EMPTY and owned by producer
- rd_address_a, rd_address_b  in  AWIDTH  consumer read addresses
- rd_done  in  1  one-cycle pulse: current drain bank consumed
- rd_valid  out  1  a bank is FULL and owned by consumer
- out_a, out_b  out  DWIDTH  read data
- fill_bank, drain_bank  out  1  current bank pointers
- wr_overflow  out  1  sticky: write or wr_done attempted while wr_ready=0
- rd_underflow  out  1  sticky: rd_done attempted while rd_valid=0

## Operation
- Two banks, each a true dual-port RAM; bank state register state[i] ∈ {EMPTY, FULL}.
- Pointers: fill_ptr selects the producer bank; drain_ptr selects the consumer bank. wr_ready = (state[fill_ptr]==EMPTY); rd_valid = (state[drain_ptr]==FULL).
- Bank i port routing:
  - If state[i]==EMPTY and fill_ptr==i: ports driven by producer; wren = wr_en_x & wr_ready.
  - If state[i]==FULL and drain_ptr==i: ports driven by rd_address_x with wren=0.
  - Otherwise: wren=0.
- wr_done with wr_ready=1: state[fill_ptr]<=FULL, fill_ptr toggles.
- rd_done with rd_valid=1: state[drain_ptr]<=EMPTY, drain_ptr toggles.
- Simultaneous wr_done and rd_done: both take effect. They always target different banks, because one requires EMPTY and the other FULL.
- Writes with wr_ready=0 are dropped and set wr_overflow. wr_done with wr_ready=0 is ignored and sets wr_overflow. rd_done with rd_valid=0 is ignored and sets rd_underflow. Sticky flags clear only on reset.
- Both write ports enabled to the same address in one cycle: port A data wins.
- Reads while rd_valid=0 return don't-care data. The bench must not check them.

## Timing
- Reset values: state[0]=state[1]=EMPTY, fill_ptr=drain_ptr=0, wr_ready=1, rd_valid=0, out_a=out_b=0, fill_bank=drain_bank=0, wr_overflow=rd_underflow=0. RAM contents are not reset.
- Write latency: a word written at edge t is readable once the bank is FULL and owned by the consumer.
- wr_done sampled at edge t: rd_valid and wr_ready update after edge t. At most one cycle passes from wr_done to rd_valid=1 if the consumer was waiting.
- Read latency is 1 cycle: rd_address presented before edge t gives out_x valid after edge t. The output mux uses drain_ptr registered at edge t.
- A read issued in the same cycle as rd_done still returns correct data on the following cycle.
- Mid-operation reset clears all state and pointers immediately (asynchronous). In-flight data is considered lost.
- Steady-state throughput: 2 words written and 2 words read per cycle.

## Structure
- Shared package: bank state constants (EMPTY=1'b0, FULL=1'b1) and default DWIDTH/AWIDTH.
- One sub-module: dpram_generic (parameters DWIDTH, AWIDTH; synchronous read, 1-cycle, no reset), instantiated twice.
- Top level holds pointers, state bits, port routing, output mux and sticky flags.

## Test plan
- Reset → wr_ready=1, rd_valid=0, out_a=out_b=0, both flags 0.
- Fill bank 0: write addr 0..2047 with data=addr via ports A/B, then pulse wr_done. Next cycle: rd_valid=1, fill_bank=1, wr_ready=1. Read addr 5 and 2047 → out_a=5, out_b=2047 one cycle later.
- Fill bank 1 while draining bank 0, then pulse wr_done with no rd_done → wr_ready=0. A further write to addr 3 is dropped and wr_overflow=1. Bank 1 addr 3 retains its original value.
- wr_done and rd_done in the same cycle → both banks swap roles, with no overflow or underflow.
- rd_done with rd_valid=0 → ignored and rd_underflow=1. Both ports write addr 7 together (A=0xA, B=0xB) → readback is 0xA.
- Assert reset mid-fill after 100 writes → all outputs return to reset values. A fresh fill and drain then passes.
